ss_wb_arb: RTL

Two-requester Wishbone master arbiter that shares the single 64-bit-read Wishbone master port between the source-side and destination-side scatter/gather engines of the ADMA channel. Requester 0 is the src/read engine; requester 1 is the dst/write engine.
Ownership is granted round-robin and held for a whole cyc cycle. An optional burst limit forces the owner off the bus by substituting a retry response, so neither engine can starve the other on long descriptor buffers.

---
 rtl/ss_wb_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ss_wb_arb.sv
// Round-robin arbiter sharing one Wishbone master port between the ADMA src (m0)
// and dst (m1) engines, with optional burst-limit preemption via forced retry.
module ss_wb_arb #(
  parameter logic [7:0] MAXBURST = 8'd16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic        m0_cab,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m0_dat64_o,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic        m1_cab,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic [31:0] m1_dat64_o,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic        wb_cab_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_dat64_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic [1:0]  arb_gnt,
  output logic [7:0]  arb_state
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT0    = 2'd1,
    S_GNT1    = 2'd2,
    S_PREEMPT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic own_sel;
  logic own_cyc;
  logic oth_cyc;
  logic in_gnt;
  logic limit_hit;

  // gnt_q[1] identifies the owner in both the granted and preempt states
  assign own_sel = gnt_q[1];
  assign own_cyc = own_sel ? m1_cyc : m0_cyc;
  assign oth_cyc = own_sel ? m0_cyc : m1_cyc;
  assign in_gnt  = (state_q == S_GNT0) || (state_q == S_GNT1);

  // Written as cnt_d + 1 > MAXBURST so the disabled case is not a constant compare
  assign limit_hit = (MAXBURST != 8'd0) &&
                     ((9'(cnt_d) + 9'd1) > 9'(MAXBURST));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_cyc && (!m1_cyc || last_gnt_q)) begin
          state_d = S_GNT0;
          gnt_d   = 2'b01;
          cnt_d   = '0;
        end else if (m1_cyc) begin
          state_d = S_GNT1;
          gnt_d   = 2'b10;
          cnt_d   = '0;
        end
      end
      S_GNT0, S_GNT1: begin
        if (wb_ack_i && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!own_cyc) begin
          state_d    = S_IDLE;
          gnt_d      = 2'b00;
          last_gnt_d = own_sel;
        end else if (limit_hit && oth_cyc) begin
          state_d = S_PREEMPT;
        end
      end
      S_PREEMPT: begin
        if (!own_cyc) begin
          state_d    = S_IDLE;
          gnt_d      = 2'b00;
          last_gnt_d = own_sel;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Slave side follows the owner combinationally; quiet outside a grant
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_cab_o = 1'b0;
    wb_sel_o = '0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    if (in_gnt) begin
      wb_cyc_o = own_cyc;
      wb_stb_o = own_sel ? m1_stb   : m0_stb;
      wb_we_o  = own_sel ? m1_we    : m0_we;
      wb_cab_o = own_sel ? m1_cab   : m0_cab;
      wb_sel_o = own_sel ? m1_sel   : m0_sel;
      wb_adr_o = own_sel ? m1_adr   : m0_adr;
      wb_dat_o = own_sel ? m1_dat_i : m0_dat_i;
    end
  end

  assign m0_ack = (state_q == S_GNT0) && wb_ack_i;
  assign m0_err = (state_q == S_GNT0) && wb_err_i;
  assign m0_rty = ((state_q == S_GNT0) && wb_rty_i) ||
                  ((state_q == S_PREEMPT) && !own_sel);
  assign m1_ack = (state_q == S_GNT1) && wb_ack_i;
  assign m1_err = (state_q == S_GNT1) && wb_err_i;
  assign m1_rty = ((state_q == S_GNT1) && wb_rty_i) ||
                  ((state_q == S_PREEMPT) && own_sel);

  assign m0_dat_o   = wb_dat_i;
  assign m1_dat_o   = wb_dat_i;
  assign m0_dat64_o = wb_dat64_i;
  assign m1_dat64_o = wb_dat64_i;

  assign arb_gnt   = gnt_q;
  assign arb_state = {(state_q == S_PREEMPT), 5'b0, state_q};

endmodule
